transpose_buffer: RTL and testbench
===================================

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

Interface
REQ-001 SHALL have parameter N, default 8: block dimension (rows, columns and elements per word).
REQ-002 SHALL have parameter W, default 8: element width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: producer has a 1D-DCT row word on in_data.
REQ-006 SHALL have port in_ready, output, 1: buffer accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, N*W: row word; element 0 in bits [N*W-1 -: W], element N-1 in bits [W-1:0].
REQ-008 SHALL have port out_valid, output, 1: out_data holds a valid column word.
REQ-009 SHALL have port out_ready, input, 1: consumer (column 1D-DCT) takes out_data this cycle.
REQ-010 SHALL have port out_data, output, N*W: column word, same element packing as in_data.
REQ-011 SHALL have port out_last, output, 1: high with out_valid on column N-1 of a block.

Function
REQ-012 SHALL hold two N x N element banks (ping-pong), each with a full flag; write bank select wr_sel, read bank select rd_sel, row counter wr_row, column counter rd_col.
REQ-013 SHALL assert in_ready = !full[wr_sel], driven only from registered state (no combinational path from out_ready or in_valid).
REQ-014 SHALL, on in_valid && in_ready, store in_data element j into bank[wr_sel][wr_row][j] for j = 0..N-1 and increment wr_row.
REQ-015 SHALL, when a row is accepted with wr_row == N-1, set full[wr_sel], toggle wr_sel and clear wr_row to 0.
REQ-016 SHALL assert out_valid = full[rd_sel]; out_data element k SHALL equal bank[rd_sel][k][rd_col] (transpose).
REQ-017 SHALL assert out_last = out_valid && (rd_col == N-1).
REQ-018 SHALL, on out_valid && out_ready, increment rd_col; at rd_col == N-1, clear full[rd_sel], toggle rd_sel and clear rd_col to 0.
REQ-019 SHALL hold out_data, out_valid and out_last stable while out_valid && !out_ready.
REQ-020 SHALL present column 0 of a block on out_valid in the cycle after the block's N-th row is accepted (latency 1 cycle).
REQ-021 SHALL, when fill-complete on one bank and drain-complete on the other occur in the same cycle, apply both updates independently.
REQ-022 SHALL, with in_valid and out_ready held high, sustain 1 row in and 1 column out per cycle indefinitely with no bubbles after the first block.
REQ-023 SHALL, with both banks full, hold in_ready low until the read bank drains; the next row is accepted the cycle after the last column handshake.
REQ-024 SHALL pass elements through unmodified (no arithmetic, no sign or width change).

Reset
REQ-025 SHALL, while rst_n is low, force full[1:0]=0, wr_sel=rd_sel=0, wr_row=rd_col=0 and all bank elements to 0.
REQ-026 SHALL therefore drive out_valid=0, out_last=0, out_data=0 and in_ready=1 during and after reset until the first accepted row.
REQ-027 SHALL, when reset asserts mid-block, discard any partial or full blocks; the first row after release is row 0 of bank 0.

Structure
REQ-028 SHALL take N and W defaults from shared package dct_pkg (constants DCT_N, DCT_W), shared with the 1D-DCT and 2D top.
REQ-029 SHALL instantiate sub-module transpose_bank twice: one N x N register bank with row-write port and column-read mux.
REQ-030 SHALL keep handshake, counters and full flags in transpose_buffer only.

Verification
REQ-031 SHALL cover reset: after release -> in_ready=1, out_valid=0, out_data=0.
REQ-032 SHALL cover single block: rows r=0..7 with element j = 8r+j, out_ready=1 -> columns c=0..7 output element k = 8k+c, out_last only on c=7, first column 1 cycle after row 7.
REQ-033 SHALL cover streaming: 4 back-to-back blocks, in_valid=out_ready=1 -> in_ready never low, out_valid continuous from cycle 9, all 32 columns correct.
REQ-034 SHALL cover backpressure: out_ready=0 while 16 rows sent -> in_ready falls after row 16 accepted; one out_ready pulse per column releases; row 17 accepted cycle after 8th column handshake.
REQ-035 SHALL cover stall stability: random out_ready toggling -> out_data/out_last unchanged on every cycle with out_valid && !out_ready.
REQ-036 SHALL cover mid-block reset: rst_n low after row 4 of block 2 -> out_valid=0 immediately; a new full block then outputs correctly from bank 0.

Source files
------------

// File: rtl/dct_pkg.sv
// dct_pkg: constants shared by the 1D-DCT, the transpose buffer and the 2D top.
package dct_pkg;
    localparam int DCT_N = 8;
    localparam int DCT_W = 8;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/transpose_bank.sv
// transpose_bank: N x N element registers written a row at a time, read a column at a time.
module transpose_bank
    import dct_pkg::*;
#(
    parameter int N = DCT_N,
    parameter int W = DCT_W,
    localparam int AW = cnt_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_row,
    input  logic [N*W-1:0]  i_data,
    input  logic [AW-1:0]   i_col,
    output logic [N*W-1:0]  o_data
);
    logic [W-1:0] r_mem [N][N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    r_mem[r][c] <= '0;
        end else if (i_we) begin
            for (int c = 0; c < N; c++)
                r_mem[i_row][c] <= i_data[(N-1-c)*W +: W];
        end
    end

    // Element 0 sits in the most significant slot of the word.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < N; k++)
            o_data[(N-1-k)*W +: W] = r_mem[k][i_col];
    end
endmodule

// File: rtl/transpose_buffer.sv
// transpose_buffer: ping-pong N x N transpose between the row and column 1D-DCT passes.
// Rows fill one bank while the other drains as columns; handshakes use registered state only.
module transpose_buffer
    import dct_pkg::*;
#(
    parameter int N = DCT_N,
    parameter int W = DCT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_data,
    output logic            out_last
);
    localparam int AW = cnt_w(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    logic [1:0]     r_full;
    logic           r_wr_sel;
    logic           r_rd_sel;
    logic [AW-1:0]  r_wr_row;
    logic [AW-1:0]  r_rd_col;
    logic           w_wr;
    logic           w_rd;
    logic           w_fill;
    logic           w_drain;
    logic [N*W-1:0] w_col [2];

    assign in_ready  = !r_full[r_wr_sel];
    assign out_valid = r_full[r_rd_sel];
    assign w_wr      = in_valid && in_ready;
    assign w_rd      = out_valid && out_ready;
    assign w_fill    = w_wr && (r_wr_row == LAST);
    assign w_drain   = w_rd && (r_rd_col == LAST);
    assign out_last  = out_valid && (r_rd_col == LAST);
    assign out_data  = w_col[r_rd_sel];

    genvar b;
    for (b = 0; b < 2; b++) begin : g_bank
        transpose_bank #(.N(N), .W(W)) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_we   (w_wr && (r_wr_sel == 1'(b))),
            .i_row  (r_wr_row),
            .i_data (in_data),
            .i_col  (r_rd_col),
            .o_data (w_col[b])
        );
    end

    // Fill and drain always target different banks, so both flag updates can land together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_wr_row <= '0;
            r_rd_col <= '0;
        end else begin
            if (w_wr) begin
                r_wr_row <= w_fill ? '0 : r_wr_row + 1'b1;
                r_wr_sel <= r_wr_sel ^ w_fill;
            end
            if (w_rd) begin
                r_rd_col <= w_drain ? '0 : r_rd_col + 1'b1;
                r_rd_sel <= r_rd_sel ^ w_drain;
            end
            for (int i = 0; i < 2; i++)
                r_full[i] <= (r_full[i] && !(w_drain && (r_rd_sel == 1'(i))))
                             || (w_fill && (r_wr_sel == 1'(i)));
        end
    end
endmodule

// File: tb/tb_transpose_buffer.sv
// tb_transpose_buffer: table-driven single block plus scoreboarded streaming,
// backpressure, stall-stability and mid-block reset sequences.
module tb_transpose_buffer;
    import dct_pkg::*;
    localparam int N  = DCT_N;
    localparam int W  = DCT_W;
    localparam int DW = N * W;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } col_t;

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_irdy;
        logic          e_ov;
        logic          e_ol;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    col_t          sb[$];
    logic [W-1:0]  blk [N][N];
    int            row_n = 0;
    logic          acc;
    logic          hs;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    vec_t          tbl [2*N+1];

    always #5 clk = ~clk;

    transpose_buffer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int j = 0; j < N; j++) r[(N-1-j)*W +: W] = W'($urandom);
        return r;
    endfunction

    // Reference transpose: a completed block yields N expected columns.
    task automatic model_accept(input logic [DW-1:0] d);
        col_t e;
        for (int j = 0; j < N; j++) blk[row_n][j] = d[(N-1-j)*W +: W];
        row_n++;
        if (row_n == N) begin
            for (int c = 0; c < N; c++) begin
                for (int k = 0; k < N; k++) e.data[(N-1-k)*W +: W] = blk[k][c];
                e.last = (c == N - 1);
                sb.push_back(e);
            end
            row_n = 0;
        end
    endtask

    // Called at a negedge: score this cycle's handshakes, then advance to just after the next posedge.
    task automatic tick();
        col_t e;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (hs) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_col: got %h expected no column", out_data);
            end else begin
                e = sb.pop_front();
                chk("col_data", out_data, e.data);
                chk("col_last", out_last, e.last);
            end
        end
        if (acc) model_accept(in_data);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        tick();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 8 * N && sb.size() > 0; t++) step();
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        int sent, bad_ir, gap, hs_cnt, last_hs, acc_cyc, early;
        logic [DW-1:0] r;
        // Single-block vectors: row r element j = N*r + j, consumer always ready.
        for (int i = 0; i <= 2 * N; i++) begin
            for (int j = 0; j < N; j++) r[(N-1-j)*W +: W] = W'(N * i + j);
            tbl[i].iv     = (i < N);
            tbl[i].id     = (i < N) ? r : '0;
            tbl[i].ordy   = 1'b1;
            tbl[i].e_irdy = 1'b1;
            tbl[i].e_ov   = (i >= N) && (i < 2 * N);
            tbl[i].e_ol   = (i == 2 * N - 1);
        end

        repeat (3) @(negedge clk);
        chk("rst_hold_in_ready", in_ready, 1'b1);
        chk("rst_hold_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i <= 2 * N; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk("tbl_in_ready", in_ready, tbl[i].e_irdy);
            chk("tbl_out_valid", out_valid, tbl[i].e_ov);
            chk("tbl_out_last", out_last, tbl[i].e_ol);
            tick();
        end
        drain();

        // Streaming: four blocks back to back.
        out_ready = 1'b1;
        sent = 0; bad_ir = 0; gap = 0;
        for (int t = 0; t < 8 * N && sent < 4 * N; t++) begin
            in_valid = 1'b1;
            in_data  = rand_row();
            @(negedge clk);
            if (!in_ready) bad_ir++;
            if (t >= N && !out_valid) gap++;
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        for (int t = 0; t < N; t++) begin
            @(negedge clk);
            if (!out_valid) gap++;
            tick();
        end
        chk("stream_rows", sent, 4 * N);
        chk("stream_in_ready_drops", bad_ir, 0);
        chk("stream_out_gaps", gap, 0);
        chk("stream_left", sb.size(), 0);

        // Backpressure: fill both banks, then release one column per pulse.
        out_ready = 1'b0;
        sent = 0;
        for (int t = 0; t < 4 * N && sent < 2 * N; t++) begin
            in_valid = 1'b1;
            in_data  = rand_row();
            step();
            if (acc) sent++;
        end
        chk("bp_rows", sent, 2 * N);
        in_data = rand_row();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 1'b0);
            tick();
        end
        hs_cnt = 0; last_hs = -100; acc_cyc = -1; early = 0;
        for (int t = 0; t < 6 * N && acc_cyc < 0; t++) begin
            out_ready = (hs_cnt < N) && (t % 2 == 0);
            @(negedge clk);
            if (hs_cnt < N && in_ready) early++;
            tick();
            if (hs) begin
                hs_cnt++;
                if (hs_cnt == N) last_hs = cyc;
            end
            if (acc) acc_cyc = cyc;
        end
        chk("bp_early_ready", early, 0);
        chk("bp_handshakes", hs_cnt, N);
        chk("bp_accept_delay", acc_cyc - last_hs, 1);
        drain();

        // Random consumer stalls; tick() checks stability on every stalled cycle.
        for (int t = 0; t < 12 * N; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = rand_row();
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        for (int t = 0; t < 8 * N && row_n != 0; t++) begin
            in_valid  = 1'b1;
            in_data   = rand_row();
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("stall_block_done", row_n, 0);
        drain();

        // Mid-block reset: one full block plus rows 0..4 of the next, then reset.
        out_ready = 1'b0;
        sent = 0;
        for (int t = 0; t < 4 * N && sent < N + 5; t++) begin
            in_valid = 1'b1;
            in_data  = rand_row();
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_out_data", out_data, '0);
        sb.delete();
        row_n = 0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        sent = 0;
        for (int t = 0; t < 4 * N && sent < N; t++) begin
            in_valid = 1'b1;
            in_data  = rand_row();
            @(negedge clk);
            chk("post_rst_out_valid", out_valid, 1'b0);
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_latency", out_valid, 1'b1);
        tick();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
